// File: rtl/alu_pkg.sv
// Shared constants for the ALU result post-processing blocks: rounding modes
// and the default result/operand widths.
package alu_pkg;
  localparam int ALU_RES_W = 55;
  localparam int ALU_OP_W  = 36;

  localparam logic [1:0] ROUND_TRUNC   = 2'd0;
  localparam logic [1:0] ROUND_HALF_UP = 2'd1;
  localparam logic [1:0] ROUND_CONV    = 2'd2;
endpackage

// File: rtl/alu_pipe_reg.sv
// One valid/ready register slice: holds a payload and its valid bit, and
// refills whenever it is empty or its contents leave this cycle.
module alu_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  // Handshake: a beat moves when valid && ready on the same edge; valid never
  // waits on ready, and a stalled payload stays unchanged until it moves.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end
endmodule

// File: rtl/alu_round_sat.sv
// Rounds the wide signed ALU sum down by FRAC bits, clamps it to OUT_W signed
// bits and keeps saturation statistics for the delivered samples.
module alu_round_sat
  import alu_pkg::*;
#(
  parameter int IN_W  = ALU_RES_W,
  parameter int FRAC  = 18,
  parameter int OUT_W = ALU_OP_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       round_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             sat_sticky,
  output logic [CNT_W-1:0] sat_count,
  input  logic             clr
);
  localparam int RW = IN_W + 1 - FRAC;
  localparam logic [IN_W:0] ONE  = {{IN_W{1'b0}}, 1'b1};
  localparam logic [IN_W:0] HALF = ONE << (FRAC - 1);
  localparam logic signed [RW-1:0] R_MAX = RW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] R_MIN = ~R_MAX;

  logic [IN_W:0] ext, bias, sum;
  logic          unused_lsbs;
  logic          s1_in_ready, s1_valid, s2_in_ready;
  logic [RW-1:0] s1_r;
  logic          sat_hi, sat_lo;
  logic [OUT_W:0] s2_payload;
  logic          sat_event;

  // The sign-extension bit absorbs the rounding carry, so the add never wraps.
  assign ext = {in_data[IN_W-1], in_data};

  always_comb begin
    bias = '0;
    case (round_mode)
      ROUND_HALF_UP: bias = HALF;
      ROUND_CONV:    bias = HALF - ONE + {{IN_W{1'b0}}, in_data[FRAC]};
      default:       bias = '0;
    endcase
  end

  assign sum         = ext + bias;
  assign unused_lsbs = ^sum[FRAC-1:0];

  alu_pipe_reg #(.W(RW)) u_round (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (s1_in_ready),
    .in_data   (sum[IN_W:FRAC]),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_r)
  );

  assign in_ready = rst && s1_in_ready;

  assign sat_hi = $signed(s1_r) > R_MAX;
  assign sat_lo = $signed(s1_r) < R_MIN;

  always_comb begin
    s2_payload = {1'b0, s1_r[OUT_W-1:0]};
    if (sat_hi)      s2_payload = {1'b1, R_MAX[OUT_W-1:0]};
    else if (sat_lo) s2_payload = {1'b1, R_MIN[OUT_W-1:0]};
  end

  alu_pipe_reg #(.W(OUT_W + 1)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({out_sat, out_data})
  );

  assign sat_event = out_valid && out_ready && out_sat;

  // A clear in the same cycle as a clipped delivery still records that delivery.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_sticky <= 1'b0;
      sat_count  <= '0;
    end else if (clr) begin
      sat_sticky <= sat_event;
      sat_count  <= sat_event ? CNT_W'(1) : '0;
    end else if (sat_event) begin
      sat_sticky <= 1'b1;
      if (sat_count != '1) sat_count <= sat_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_alu_round_sat.sv
// Bench for alu_round_sat: directed rounding/saturation/flow-control steps plus
// a random phase, scored against an arithmetic reference model.
module tb_alu_round_sat;
  localparam int IN_W    = 55;
  localparam int FRAC    = 18;
  localparam int OUT_W   = 36;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       round_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;
  logic             sat_sticky;
  logic [CNT_W-1:0] sat_count;
  logic             clr;

  logic [OUT_W:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int m_count = 0;
  bit m_sticky = 1'b0;
  bit hold_prev = 1'b0;
  logic [OUT_W:0] held;
  bit last_in_fire, last_out_fire;
  int n_out = 0;

  localparam logic [IN_W-1:0] POS_BIG = 55'h3FFFFFFFFFFFFF;
  localparam logic [IN_W-1:0] NEG_BIG = 55'h40000000000000;

  alu_round_sat #(.IN_W(IN_W), .FRAC(FRAC), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .round_mode (round_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .sat_sticky (sat_sticky),
    .sat_count  (sat_count),
    .clr        (clr)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [OUT_W:0] model(input logic [IN_W-1:0] d, input logic [1:0] m);
    longint v, q, rem, half, lim_hi, lim_lo;
    logic sat;
    v = longint'($signed(d));
    q = v >>> FRAC;
    rem = v - (q <<< FRAC);
    half = longint'(1) <<< (FRAC - 1);
    if (m == 2'd1 && rem >= half) q = q + 1;
    else if (m == 2'd2 && (rem > half || (rem == half && q[0]))) q = q + 1;
    lim_hi = (longint'(1) <<< (OUT_W - 1)) - 1;
    lim_lo = -lim_hi - 1;
    sat = 1'b0;
    if (q > lim_hi) begin q = lim_hi; sat = 1'b1; end
    else if (q < lim_lo) begin q = lim_lo; sat = 1'b1; end
    return {sat, q[OUT_W-1:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver / scoreboard per clock ----------------
  task automatic cycle();
    logic [OUT_W:0] e;
    bit ev;
    @(negedge clk);
    last_in_fire  = in_valid && in_ready;
    last_out_fire = out_valid && out_ready;
    ev = 1'b0;
    if (!rst) begin
      chk("rst_in_ready", in_ready, 0);
    end else begin
      chk("in_ready", in_ready, !(exp_q.size() == 2 && !out_ready));
      chk("sat_sticky", sat_sticky, m_sticky);
      chk("sat_count", sat_count, m_count);
      if (exp_q.size() == 0) chk("idle_valid", out_valid, 0);
      if (hold_prev) chk("stall_hold", {out_sat, out_data}, held);
      if (last_out_fire) begin
        n_out++;
        chk("out_has_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e[OUT_W-1:0]);
          chk("out_sat", out_sat, e[OUT_W]);
          ev = e[OUT_W];
        end
      end
      if (last_in_fire) exp_q.push_back(model(in_data, round_mode));
    end
    hold_prev = rst && out_valid && !out_ready;
    held = {out_sat, out_data};
    @(posedge clk);
    if (rst) begin
      if (clr) begin m_count = 0; m_sticky = 1'b0; end
      if (ev) begin
        m_sticky = 1'b1;
        if (m_count < CNT_MAX) m_count++;
      end
    end
    #1;
  endtask

  task automatic send_check(input string tag, input logic [IN_W-1:0] d, input logic [1:0] m,
                            input logic [OUT_W-1:0] ed, input logic es);
    in_valid = 1'b1; in_data = d; round_mode = m; out_ready = 1'b1;
    cycle();
    chk({tag, "_accept"}, last_in_fire, 1);
    in_valid = 1'b0; in_data = IN_W'({$urandom(), $urandom()});
    round_mode = 2'($urandom_range(0, 3));
    chk({tag, "_lat1"}, out_valid, 0);
    cycle();
    chk({tag, "_lat2"}, out_valid, 1);
    chk({tag, "_data"}, out_data, ed);
    chk({tag, "_sat"}, out_sat, es);
    cycle();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] bp_pat;
    logic [63:0] r64;
    int k, n0, acc;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; round_mode = 2'd0;
    out_ready = 1'b0; clr = 1'b0;
    #3 rst = 1'b0;
    #20;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_sat", out_sat, 0);
    chk("reset_sticky", sat_sticky, 0);
    chk("reset_count", sat_count, 0);
    chk("reset_in_ready", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // truncation and latency
    send_check("trunc", (55'd5 << 18) + 55'h1FFFF, 2'd0, 36'd5, 1'b0);
    send_check("trunc_neg", -55'sd131072, 2'd0, 36'hFFFFFFFFF, 1'b0);
    // rounding at exactly one half
    send_check("hu_5h", (55'd5 << 18) + (55'd1 << 17), 2'd1, 36'd6, 1'b0);
    send_check("cv_5h", (55'd5 << 18) + (55'd1 << 17), 2'd2, 36'd6, 1'b0);
    send_check("hu_4h", (55'd4 << 18) + (55'd1 << 17), 2'd1, 36'd5, 1'b0);
    send_check("cv_4h", (55'd4 << 18) + (55'd1 << 17), 2'd2, 36'd4, 1'b0);
    send_check("hu_neg", -55'sd131072, 2'd1, 36'd0, 1'b0);
    send_check("cv_neg", -55'sd131072, 2'd2, 36'd0, 1'b0);
    send_check("m3_trunc", (55'd5 << 18) + (55'd1 << 17), 2'd3, 36'd5, 1'b0);

    // saturation
    send_check("sat_pos", POS_BIG, 2'd0, 36'h7FFFFFFFF, 1'b1);
    chk("sat_pos_sticky", sat_sticky, 1);
    chk("sat_pos_count", sat_count, 1);
    send_check("sat_neg", NEG_BIG, 2'd0, 36'h800000000, 1'b1);
    chk("sat_neg_count", sat_count, 2);
    send_check("carry_t", (55'h7FFFFFFFF << 18) | (55'd1 << 17), 2'd0, 36'h7FFFFFFFF, 1'b0);
    send_check("carry_hu", (55'h7FFFFFFFF << 18) | (55'd1 << 17), 2'd1, 36'h7FFFFFFFF, 1'b1);
    chk("carry_count", sat_count, 3);

    // backpressure stream
    bp_pat = 8'b0110_1001;
    k = 1; n0 = n_out;
    for (int p = 0; p < 100 && (k <= 8 || exp_q.size() > 0); p++) begin
      out_ready = bp_pat[p % 8];
      in_valid = (k <= 8);
      in_data = IN_W'(k) << FRAC;
      round_mode = 2'($urandom_range(0, 3));
      cycle();
      if (last_in_fire) k++;
    end
    in_valid = 1'b0;
    chk("bp_delivered", n_out - n0, 8);

    // counter limits
    clr = 1'b1; out_ready = 1'b1; cycle(); clr = 1'b0;
    chk("clr_count", sat_count, 0);
    acc = 0;
    for (int p = 0; p < 200 && (acc < 20 || exp_q.size() > 0); p++) begin
      in_valid = (acc < 20); in_data = POS_BIG; round_mode = 2'd0;
      cycle();
      if (last_in_fire) acc++;
    end
    in_valid = 1'b0;
    chk("cnt_limit", sat_count, CNT_MAX);
    chk("cnt_limit_sticky", sat_sticky, 1);
    in_valid = 1'b1; in_data = NEG_BIG; cycle();
    in_valid = 1'b0; cycle();
    chk("clr_evt_valid", out_valid, 1);
    clr = 1'b1; cycle(); clr = 1'b0;
    chk("clr_evt_count", sat_count, 1);
    chk("clr_evt_sticky", sat_sticky, 1);
    clr = 1'b1; cycle(); clr = 1'b0;
    chk("clr_only_count", sat_count, 0);
    chk("clr_only_sticky", sat_sticky, 0);

    // random traffic
    for (int p = 0; p < 400; p++) begin
      r64 = {$urandom(), $urandom()};
      case ($urandom_range(0, 2))
        0: in_data = r64[IN_W-1:0];
        1: in_data = {{(IN_W-40){r64[39]}}, r64[39:0]};
        default: in_data = (r64[0] ? NEG_BIG >>> 1 | NEG_BIG : POS_BIG >> 1)
                         + {{(IN_W-20){r64[20]}}, r64[20:1]};
      endcase
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 9) < 7);
      round_mode = 2'($urandom_range(0, 3));
      clr        = ($urandom_range(0, 15) == 0);
      cycle();
    end
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int p = 0; p < 10 && exp_q.size() > 0; p++) cycle();

    // reset with samples in flight
    send_check("pre_rst", POS_BIG, 2'd0, 36'h7FFFFFFFF, 1'b1);
    out_ready = 1'b0; in_valid = 1'b1;
    for (int p = 0; p < 3; p++) begin
      in_data = IN_W'(p + 1) << FRAC;
      cycle();
    end
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_count", sat_count, 0);
    chk("mid_rst_sticky", sat_sticky, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    exp_q.delete(); m_count = 0; m_sticky = 1'b0; hold_prev = 1'b0;
    cycle(); cycle();
    #2 rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1;
    cycle(); cycle(); cycle();
    send_check("post_rst", 55'd7 << 18, 2'd0, 36'd7, 1'b0);
    for (int p = 0; p < 10 && exp_q.size() > 0; p++) cycle();
    chk("final_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
